// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pkg
// Purpose : Shared types and constants for the fetch unit and its LUT.
// Rev     : 1.0  initial release
// ============================================================================
package fetch_pkg;
  // Nominal PC width, matching the 256-entry instruction memory
  localparam int PKG_PC_W = 8;
  // Branch LUT index width; the 9-bit ISA carries a 4-bit index
  localparam int LUT_IDX_W = 4;
  // PC loaded when fetching begins
  localparam int DEFAULT_START_ADDR = 0;

  typedef logic [PKG_PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;
endpackage
`default_nettype wire

// File: rtl/fetch_unit_branch_lut.sv
`default_nettype none
// ============================================================================
// Module  : branch_lut
// Purpose : Small writable table of branch targets / offsets. Registered
//           write, combinational read, cleared by synchronous reset.
// Rev     : 1.0  initial release
// ============================================================================
module branch_lut #(
  parameter int  LUT_DEPTH = 16,
  parameter int  PC_W      = 8,
  localparam int IDX_W     = $clog2(LUT_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [PC_W-1:0]  wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [PC_W-1:0]  rdata
);
  logic [PC_W-1:0] mem [LUT_DEPTH];

  // Clear every entry on reset, otherwise accept one write per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Read sees stored contents only, so a same-cycle write is not forwarded
  assign rdata = mem[ridx];
endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Purpose : Program counter and fetch sequencer in front of the instruction
//           memory. Handles start, stall, halt, end-of-program and branches
//           resolved through a small target LUT.
// Rev     : 1.0  initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int  PC_W       = PKG_PC_W,
  parameter int  START_ADDR = DEFAULT_START_ADDR,
  parameter int  LUT_DEPTH  = 2 ** LUT_IDX_W,
  parameter int  CNT_W      = 16,
  parameter bit  WRAP_HALT  = 1'b0,
  localparam int IDX_W      = $clog2(LUT_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             imem_done,
  input  logic             branch_taken,
  input  logic             branch_rel,
  input  logic [IDX_W-1:0] branch_idx,
  input  logic             lut_we,
  input  logic [IDX_W-1:0] lut_idx,
  input  logic [PC_W-1:0]  lut_data,
  output logic [PC_W-1:0]  pc,
  output logic             pc_valid,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);
  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] PC_MAX   = '1;

  fetch_state_t    state;
  logic            first;    // first RUN cycle: memory done is still stale
  logic            stall_q;  // stall seen on the previous edge
  logic [PC_W-1:0] lut_rdata;

  branch_lut #(
    .LUT_DEPTH (LUT_DEPTH),
    .PC_W      (PC_W)
  ) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .widx  (lut_idx),
    .wdata (lut_data),
    .ridx  (branch_idx),
    .rdata (lut_rdata)
  );

  // Status outputs decode registered state only
  assign running  = (state == RUN);
  assign halted   = (state == HALT);
  assign pc_valid = running && !first && !stall_q;

  // Sequencer FSM, next-PC selection and saturating fetch counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= START_PC;
      first       <= 1'b0;
      stall_q     <= 1'b0;
      fetch_count <= '0;
    end else begin
      stall_q <= stall;
      if (pc_valid && (fetch_count != '1)) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state <= RUN;
            pc    <= START_PC;
            first <= 1'b1;
          end
        end
        RUN: begin
          first <= 1'b0;
          if (halt_req) begin
            state <= HALT;
          end else if (imem_done && !first) begin
            state <= HALT;
          end else if (stall) begin
            pc <= pc;  // a branch alongside stall is dropped; requester re-asserts
          end else if (branch_taken) begin
            pc <= branch_rel ? (pc + lut_rdata) : lut_rdata;
          end else if (WRAP_HALT && (pc == PC_MAX)) begin
            state <= HALT;
          end else begin
            pc <= pc + PC_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          first <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_unit
// Purpose : Self-checking bench for fetch_unit. Two instances share stimulus,
//           one wrapping and one halting at the top of the address space.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [7:0] F_RST   = 8'h80;
  localparam logic [7:0] F_START = 8'h40;
  localparam logic [7:0] F_STALL = 8'h20;
  localparam logic [7:0] F_HALT  = 8'h10;
  localparam logic [7:0] F_DONE  = 8'h08;
  localparam logic [7:0] F_BR    = 8'h04;
  localparam logic [7:0] F_REL   = 8'h02;
  localparam logic [7:0] F_WE    = 8'h01;

  logic       clk = 1'b0;
  logic       reset = 1'b0, start = 1'b0, stall = 1'b0, halt_req = 1'b0;
  logic       imem_done = 1'b0, branch_taken = 1'b0, branch_rel = 1'b0, lut_we = 1'b0;
  logic [3:0] branch_idx = '0, lut_idx = '0;
  logic [7:0] lut_data = '0;

  pc_t         pc0, pc1;
  logic        v0, v1, r0, r1, h0, h1;
  logic [15:0] cnt0, cnt1;

  int tests = 0;
  int fails = 0;

  // One cycle of stimulus plus the outputs expected right after its edge
  typedef struct {
    logic [7:0] flags;
    logic [3:0] bidx;
    logic [3:0] widx;
    logic [7:0] wdata;
    pc_t        pc0;
    logic       v0, r0, h0;
    pc_t        pc1;
    logic       v1, r1, h1;
    int         ecnt;  // -1: count not checked on this step
  } step_t;

  step_t sb[$];

  always #5 clk = ~clk;

  fetch_unit #(.WRAP_HALT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
    .imem_done(imem_done), .branch_taken(branch_taken), .branch_rel(branch_rel),
    .branch_idx(branch_idx), .lut_we(lut_we), .lut_idx(lut_idx), .lut_data(lut_data),
    .pc(pc0), .pc_valid(v0), .running(r0), .halted(h0), .fetch_count(cnt0)
  );

  fetch_unit #(.WRAP_HALT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
    .imem_done(imem_done), .branch_taken(branch_taken), .branch_rel(branch_rel),
    .branch_idx(branch_idx), .lut_we(lut_we), .lut_idx(lut_idx), .lut_data(lut_data),
    .pc(pc1), .pc_valid(v1), .running(r1), .halted(h1), .fetch_count(cnt1)
  );

  function automatic step_t mk(input logic [7:0] f, input logic [3:0] bi, input logic [3:0] wi,
                               input logic [7:0] wd, input pc_t p, input logic v, input logic r,
                               input logic h);
    step_t s;
    s.flags = f; s.bidx = bi; s.widx = wi; s.wdata = wd;
    s.pc0 = p; s.v0 = v; s.r0 = r; s.h0 = h;
    s.pc1 = p; s.v1 = v; s.r1 = r; s.h1 = h;
    s.ecnt = -1;
    return s;
  endfunction

  function automatic step_t wc(input step_t s, input int c);
    step_t t;
    t = s; t.ecnt = c;
    return t;
  endfunction

  function automatic step_t alt1(input step_t s, input pc_t p, input logic v, input logic r,
                                 input logic h);
    step_t t;
    t = s; t.pc1 = p; t.v1 = v; t.r1 = r; t.h1 = h;
    return t;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, advance past the edge
  task automatic apply(input step_t s);
    logic [7:0] f;
    f = s.flags;
    reset = f[7]; start = f[6]; stall = f[5]; halt_req = f[4];
    imem_done = f[3]; branch_taken = f[2]; branch_rel = f[1]; lut_we = f[0];
    branch_idx = s.bidx; lut_idx = s.widx; lut_data = s.wdata;
    sb.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t seq[$];
    step_t e;
    seq.push_back(wc(mk(F_RST, 0, 0, 0, 8'h00, 0, 0, 0), 0));
    seq.push_back(wc(mk(F_RST | F_START | F_WE, 0, 1, 8'h55, 8'h00, 0, 0, 0), 0));
    foreach (seq[i]) begin
      apply(seq[i]);
      e = sb.pop_front();
      if (pc0 !== e.pc0 || v0 !== e.v0 || r0 !== e.r0 || h0 !== e.h0 ||
          pc1 !== e.pc1 || v1 !== e.v1 || r1 !== e.r1 || h1 !== e.h1 ||
          (e.ecnt >= 0 && (cnt0 !== 16'(e.ecnt) || cnt1 !== 16'(e.ecnt)))) begin
        fails++;
        $display("FAIL reset step %0d: got pc=%h/%h v=%b/%b r=%b/%b h=%b/%b cnt=%0d/%0d want pc=%h/%h v=%b/%b r=%b/%b h=%b/%b cnt=%0d",
                 i, pc0, pc1, v0, v1, r0, r1, h0, h1, cnt0, cnt1, e.pc0, e.pc1, e.v0, e.v1, e.r0, e.r1, e.h0, e.h1, e.ecnt);
      end
      tests++;
    end
  endtask

  task automatic test_sequential();
    step_t seq[$];
    step_t e;
    seq.push_back(mk(F_RST, 0, 0, 0, 8'h00, 0, 0, 0));
    seq.push_back(mk(F_RST, 0, 0, 0, 8'h00, 0, 0, 0));
    seq.push_back(wc(mk(F_START, 0, 0, 0, 8'h00, 0, 1, 0), 0));
    for (int p = 1; p <= 3; p++) seq.push_back(mk(0, 0, 0, 0, pc_t'(p), 1, 1, 0));
    seq.push_back(wc(mk(0, 0, 0, 0, 8'h04, 1, 1, 0), 3));
    foreach (seq[i]) begin
      apply(seq[i]);
      e = sb.pop_front();
      if (pc0 !== e.pc0 || v0 !== e.v0 || r0 !== e.r0 || h0 !== e.h0 ||
          pc1 !== e.pc1 || v1 !== e.v1 || r1 !== e.r1 || h1 !== e.h1 ||
          (e.ecnt >= 0 && (cnt0 !== 16'(e.ecnt) || cnt1 !== 16'(e.ecnt)))) begin
        fails++;
        $display("FAIL sequential step %0d: got pc=%h/%h v=%b/%b r=%b/%b h=%b/%b cnt=%0d/%0d want pc=%h/%h v=%b/%b r=%b/%b h=%b/%b cnt=%0d",
                 i, pc0, pc1, v0, v1, r0, r1, h0, h1, cnt0, cnt1, e.pc0, e.pc1, e.v0, e.v1, e.r0, e.r1, e.h0, e.h1, e.ecnt);
      end
      tests++;
    end
  endtask

  task automatic test_done_halt();
    step_t seq[$];
    step_t e;
    seq.push_back(mk(F_RST, 0, 0, 0, 8'h00, 0, 0, 0));
    seq.push_back(mk(F_START, 0, 0, 0, 8'h00, 0, 1, 0));
    seq.push_back(mk(F_DONE, 0, 0, 0, 8'h01, 1, 1, 0));        // stale done ignored
    for (int p = 2; p <= 4; p++) seq.push_back(mk(0, 0, 0, 0, pc_t'(p), 1, 1, 0));
    seq.push_back(wc(mk(F_DONE, 0, 0, 0, 8'h04, 0, 0, 1), 4));  // real end of program
    seq.push_back(wc(mk(0, 0, 0, 0, 8'h04, 0, 0, 1), 4));
    seq.push_back(wc(mk(F_START, 0, 0, 0, 8'h00, 0, 1, 0), 4)); // restart keeps count
    seq.push_back(mk(0, 0, 0, 0, 8'h01, 1, 1, 0));
    seq.push_back(wc(mk(F_HALT, 0, 0, 0, 8'h01, 0, 0, 1), 5));
    foreach (seq[i]) begin
      apply(seq[i]);
      e = sb.pop_front();
      if (pc0 !== e.pc0 || v0 !== e.v0 || r0 !== e.r0 || h0 !== e.h0 ||
          pc1 !== e.pc1 || v1 !== e.v1 || r1 !== e.r1 || h1 !== e.h1 ||
          (e.ecnt >= 0 && (cnt0 !== 16'(e.ecnt) || cnt1 !== 16'(e.ecnt)))) begin
        fails++;
        $display("FAIL done_halt step %0d: got pc=%h/%h v=%b/%b r=%b/%b h=%b/%b cnt=%0d/%0d want pc=%h/%h v=%b/%b r=%b/%b h=%b/%b cnt=%0d",
                 i, pc0, pc1, v0, v1, r0, r1, h0, h1, cnt0, cnt1, e.pc0, e.pc1, e.v0, e.v1, e.r0, e.r1, e.h0, e.h1, e.ecnt);
      end
      tests++;
    end
  endtask

  task automatic test_branch();
    step_t seq[$];
    step_t e;
    seq.push_back(mk(F_RST, 0, 0, 0, 8'h00, 0, 0, 0));
    seq.push_back(mk(F_WE, 0, 3, 8'h20, 8'h00, 0, 0, 0));
    seq.push_back(mk(F_WE, 0, 4, 8'h01, 8'h00, 0, 0, 0));
    seq.push_back(mk(F_START, 0, 0, 0, 8'h00, 0, 1, 0));
    for (int p = 1; p <= 5; p++) seq.push_back(mk(0, 0, 0, 0, pc_t'(p), 1, 1, 0));
    seq.push_back(mk(F_BR, 3, 0, 0, 8'h20, 1, 1, 0));          // absolute
    seq.push_back(mk(F_WE, 0, 3, 8'hFE, 8'h21, 1, 1, 0));
    seq.push_back(mk(F_BR, 4, 0, 0, 8'h01, 1, 1, 0));
    seq.push_back(mk(F_BR | F_REL, 3, 0, 0, 8'hFF, 1, 1, 0));  // 01 + (-2)
    foreach (seq[i]) begin
      apply(seq[i]);
      e = sb.pop_front();
      if (pc0 !== e.pc0 || v0 !== e.v0 || r0 !== e.r0 || h0 !== e.h0 ||
          pc1 !== e.pc1 || v1 !== e.v1 || r1 !== e.r1 || h1 !== e.h1 ||
          (e.ecnt >= 0 && (cnt0 !== 16'(e.ecnt) || cnt1 !== 16'(e.ecnt)))) begin
        fails++;
        $display("FAIL branch step %0d: got pc=%h/%h v=%b/%b r=%b/%b h=%b/%b cnt=%0d/%0d want pc=%h/%h v=%b/%b r=%b/%b h=%b/%b cnt=%0d",
                 i, pc0, pc1, v0, v1, r0, r1, h0, h1, cnt0, cnt1, e.pc0, e.pc1, e.v0, e.v1, e.r0, e.r1, e.h0, e.h1, e.ecnt);
      end
      tests++;
    end
  endtask

  task automatic test_stall();
    step_t seq[$];
    step_t e;
    seq.push_back(mk(F_RST, 0, 0, 0, 8'h00, 0, 0, 0));
    seq.push_back(mk(F_WE, 0, 5, 8'h30, 8'h00, 0, 0, 0));
    seq.push_back(mk(F_START, 0, 0, 0, 8'h00, 0, 1, 0));
    for (int p = 1; p <= 7; p++) seq.push_back(mk(0, 0, 0, 0, pc_t'(p), 1, 1, 0));
    for (int k = 0; k < 3; k++) seq.push_back(wc(mk(F_STALL | F_BR, 5, 0, 0, 8'h07, 0, 1, 0), 7));
    seq.push_back(wc(mk(F_BR, 5, 0, 0, 8'h30, 1, 1, 0), 7));
    seq.push_back(wc(mk(0, 0, 0, 0, 8'h31, 1, 1, 0), 8));
    foreach (seq[i]) begin
      apply(seq[i]);
      e = sb.pop_front();
      if (pc0 !== e.pc0 || v0 !== e.v0 || r0 !== e.r0 || h0 !== e.h0 ||
          pc1 !== e.pc1 || v1 !== e.v1 || r1 !== e.r1 || h1 !== e.h1 ||
          (e.ecnt >= 0 && (cnt0 !== 16'(e.ecnt) || cnt1 !== 16'(e.ecnt)))) begin
        fails++;
        $display("FAIL stall step %0d: got pc=%h/%h v=%b/%b r=%b/%b h=%b/%b cnt=%0d/%0d want pc=%h/%h v=%b/%b r=%b/%b h=%b/%b cnt=%0d",
                 i, pc0, pc1, v0, v1, r0, r1, h0, h1, cnt0, cnt1, e.pc0, e.pc1, e.v0, e.v1, e.r0, e.r1, e.h0, e.h1, e.ecnt);
      end
      tests++;
    end
  endtask

  task automatic test_wrap();
    step_t seq[$];
    step_t e;
    seq.push_back(mk(F_RST, 0, 0, 0, 8'h00, 0, 0, 0));
    seq.push_back(mk(F_WE, 0, 6, 8'hFD, 8'h00, 0, 0, 0));
    seq.push_back(mk(F_START, 0, 0, 0, 8'h00, 0, 1, 0));
    seq.push_back(mk(F_BR, 6, 0, 0, 8'hFD, 1, 1, 0));
    seq.push_back(mk(0, 0, 0, 0, 8'hFE, 1, 1, 0));
    seq.push_back(mk(0, 0, 0, 0, 8'hFF, 1, 1, 0));
    seq.push_back(alt1(mk(0, 0, 0, 0, 8'h00, 1, 1, 0), 8'hFF, 0, 0, 1));
    seq.push_back(alt1(mk(0, 0, 0, 0, 8'h01, 1, 1, 0), 8'hFF, 0, 0, 1));
    foreach (seq[i]) begin
      apply(seq[i]);
      e = sb.pop_front();
      if (pc0 !== e.pc0 || v0 !== e.v0 || r0 !== e.r0 || h0 !== e.h0 ||
          pc1 !== e.pc1 || v1 !== e.v1 || r1 !== e.r1 || h1 !== e.h1 ||
          (e.ecnt >= 0 && (cnt0 !== 16'(e.ecnt) || cnt1 !== 16'(e.ecnt)))) begin
        fails++;
        $display("FAIL wrap step %0d: got pc=%h/%h v=%b/%b r=%b/%b h=%b/%b cnt=%0d/%0d want pc=%h/%h v=%b/%b r=%b/%b h=%b/%b cnt=%0d",
                 i, pc0, pc1, v0, v1, r0, r1, h0, h1, cnt0, cnt1, e.pc0, e.pc1, e.v0, e.v1, e.r0, e.r1, e.h0, e.h1, e.ecnt);
      end
      tests++;
    end
  endtask

  task automatic test_reset_mid();
    step_t seq[$];
    step_t e;
    seq.push_back(mk(F_RST, 0, 0, 0, 8'h00, 0, 0, 0));
    seq.push_back(mk(F_WE, 0, 1, 8'h40, 8'h00, 0, 0, 0));
    seq.push_back(mk(F_START, 0, 0, 0, 8'h00, 0, 1, 0));
    for (int p = 1; p <= 9; p++) seq.push_back(mk(0, 0, 0, 0, pc_t'(p), 1, 1, 0));
    seq.push_back(wc(mk(F_RST, 0, 0, 0, 8'h00, 0, 0, 0), 0));
    seq.push_back(wc(mk(F_START, 0, 0, 0, 8'h00, 0, 1, 0), 0));
    seq.push_back(mk(F_BR, 1, 0, 0, 8'h00, 1, 1, 0));          // lut[1] cleared
    seq.push_back(mk(F_WE, 0, 2, 8'h50, 8'h01, 1, 1, 0));
    seq.push_back(mk(F_WE | F_BR, 2, 2, 8'h60, 8'h50, 1, 1, 0)); // old value used
    seq.push_back(wc(mk(F_BR, 2, 0, 0, 8'h60, 1, 1, 0), 3));
    foreach (seq[i]) begin
      apply(seq[i]);
      e = sb.pop_front();
      if (pc0 !== e.pc0 || v0 !== e.v0 || r0 !== e.r0 || h0 !== e.h0 ||
          pc1 !== e.pc1 || v1 !== e.v1 || r1 !== e.r1 || h1 !== e.h1 ||
          (e.ecnt >= 0 && (cnt0 !== 16'(e.ecnt) || cnt1 !== 16'(e.ecnt)))) begin
        fails++;
        $display("FAIL reset_mid step %0d: got pc=%h/%h v=%b/%b r=%b/%b h=%b/%b cnt=%0d/%0d want pc=%h/%h v=%b/%b r=%b/%b h=%b/%b cnt=%0d",
                 i, pc0, pc1, v0, v1, r0, r1, h0, h1, cnt0, cnt1, e.pc0, e.pc1, e.v0, e.v1, e.r0, e.r1, e.h0, e.h1, e.ecnt);
      end
      tests++;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_done_halt();
    test_branch();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch sequencer sitting directly upstream of instruction_memory.
- Drives `pc` into the memory's 8-bit `addr`, and consumes the memory's registered `done` flag as end-of-program.
- Applies stall, halt and branch requests from the decoder.
- Holds a small writable branch-target lookup table so the 9-bit ISA can branch through 4-bit indices.

Parameters:
- PC_W, 8, PC / instruction address width (matches instruction memory depth 256).
- START_ADDR, 0, PC loaded on start.
- LUT_DEPTH, 16, number of branch-target entries (index width = clog2).
- CNT_W, 16, fetch counter width.
- WRAP_HALT, 0, 1: sequential increment past 2^PC_W-1 halts; 0: wraps to 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- start  in  1  leave IDLE/HALT and begin fetching at START_ADDR.
- stall  in  1  hold PC this cycle.
- halt_req  in  1  decoder saw halt instruction.
- imem_done  in  1  instruction memory `done`; refers to the PC presented one cycle earlier.
- branch_taken  in  1  take branch this cycle.
- branch_rel  in  1  1: PC-relative (signed LUT value); 0: absolute.
- branch_idx  in  4  LUT index for branch target.
- lut_we  in  1  write LUT entry.
- lut_idx  in  4  LUT write index.
- lut_data  in  PC_W  LUT write data.
- pc  out  PC_W  fetch address to instruction memory.
- pc_valid  out  1  instruction at `pc` is to be executed this cycle.
- running  out  1  FSM in RUN.
- halted  out  1  FSM in HALT.
- fetch_count  out  CNT_W  number of cycles with pc_valid=1.

Behaviour:
- **Reset values**
  - state=IDLE, pc=START_ADDR.
  - pc_valid=0, running=0, halted=0, fetch_count=0.
  - All LUT entries = 0.
  - Reset overrides every other input, including mid-RUN.
- **States:** IDLE, RUN, HALT. All outputs are registered or decoded from registered state; none are combinational from inputs.
  - running = (state==RUN); halted = (state==HALT).
  - pc_valid = running && !first && !stall_q, where first is a flag set on entry to RUN for one cycle.
- **IDLE**
  - imem_done ignored; it is 1 out of memory reset.
  - start=1 -> RUN, pc=START_ADDR, first=1.
- **RUN, next-PC priority** (highest first):
  1. halt_req -> HALT, pc held.
  2. imem_done && !first -> HALT, pc held.
  3. stall -> pc held; a branch asserted together with stall is ignored, so the requester must hold it.
  4. branch_taken, absolute -> pc = lut[branch_idx].
  5. branch_taken, relative -> pc = pc + sign_extend(lut[branch_idx]), modulo 2^PC_W.
  6. Otherwise pc = pc+1.
- **first flag:** cleared after one RUN cycle. It masks imem_done, because that done reflects the address presented before RUN began.
- **Wrap:** increment from 2^PC_W-1 yields 0 when WRAP_HALT=0. When WRAP_HALT=1 it enters HALT with pc held at 2^PC_W-1. Branches always wrap modulo.
- **HALT**
  - pc held, pc_valid=0, fetch_count frozen.
  - start=1 -> RUN at START_ADDR, first=1.
  - fetch_count is not cleared by start; only reset clears it.
- **fetch_count:** +1 each cycle pc_valid=1; saturates at all-ones.
- **LUT**
  - Synchronous write on lut_we, accepted in every state (not during reset).
  - Reads are combinational from stored contents.
  - Write and branch to the same index in one cycle: the branch uses the old value; the new value is visible next cycle.
- **Latency:** pc changes one clock after the qualifying input. The instruction for pc is available combinationally from memory in the same cycle.

Decomposition:
- **fetch_pkg:** fetch_state_t enum {IDLE, RUN, HALT}; pc_t (logic[PC_W-1:0]); LUT_IDX_W constant; START_ADDR default.
- **Sub-module branch_lut:**
  - Parameters: LUT_DEPTH, PC_W.
  - Ports: clk, reset, we, widx, wdata, ridx, rdata.
  - Synchronous clear on reset, registered write, combinational read.
- **FSM, PC mux and counter** remain in fetch_unit.

Test Plan:
1. Reset held 2 cycles, then start at cycle 3, no other inputs -> pc = 0,1,2,3... with pc_valid low in the first RUN cycle and high thereafter; fetch_count=3 after three valid cycles.
2. imem_done=1 during the first RUN cycle (stale), then imem_done=1 when pc=4 -> first ignored; state HALT one cycle later, pc stays 4, pc_valid=0, halted=1.
3. lut[3]=8'h20 written; branch_taken, branch_rel=0, idx=3 at pc=5 -> next pc=8'h20. With lut[3]=8'hFE and branch_rel=1 at pc=8'h01 -> next pc=8'hFF.
4. stall for 3 cycles with branch_taken asserted at pc=7 -> pc holds 7, pc_valid=0, count frozen; branch taken on the first unstalled cycle.
5. Run to pc=8'hFF: WRAP_HALT=0 -> next pc=0, still RUN; WRAP_HALT=1 -> HALT with pc=8'hFF.
6. Reset asserted mid-RUN at pc=9 with lut[1]=8'h40 -> next cycle IDLE, pc=0, fetch_count=0, lut[1]=0; same-cycle lut write to idx 2 with a branch to idx 2 uses the old value.
